// File: rtl/cpu_bus_sequencer.sv
// Table-driven instruction-bus sequencer for the cpu core: plays loaded bus words with per-entry
// hold times and interrupt flags, and counts bus activity reported back by the core.
module cpu_bus_sequencer #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 64,
  parameter int unsigned HOLD_WIDTH = 8,
  parameter int unsigned CTRL_WIDTH = 4,
  parameter int unsigned IDX_W      = $clog2(DEPTH)
) (
  input  logic                  clk_from_external,
  input  logic                  reset_from_external,
  input  logic                  load_valid,
  input  logic [DATA_WIDTH-1:0] load_data,
  input  logic [HOLD_WIDTH-1:0] load_hold,
  input  logic                  load_irq,
  output logic                  load_ready,
  input  logic                  clear,
  input  logic                  start,
  input  logic                  loop_mode,
  input  logic                  abort,
  input  logic                  interrupt_grant_from_pc,
  input  logic [CTRL_WIDTH-1:0] control_output_from_cpu,
  output logic [DATA_WIDTH-1:0] inputdata_to_cpu,
  output logic                  interrupt_to_cpu,
  output logic                  busy,
  output logic                  done,
  output logic [IDX_W:0]        entry_count,
  output logic [IDX_W-1:0]      play_index,
  output logic [15:0]           bus_activity_count,
  output logic                  irq_grant_seen
);

  localparam logic [IDX_W:0] Full = (IDX_W+1)'(DEPTH);

  typedef enum logic {StIdle, StPlay} state_e;

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] data_mem [DEPTH];
  logic [HOLD_WIDTH-1:0] hold_mem [DEPTH];
  logic [DEPTH-1:0]      irq_mem;

  logic [IDX_W:0]        count_q, count_d;
  logic [IDX_W-1:0]      idx_q, idx_d, nxt_idx;
  logic [HOLD_WIDTH-1:0] hold_q, hold_d;
  logic                  acked_q, acked_d;
  logic [DATA_WIDTH-1:0] bus_q, bus_d;
  logic                  irq_q, irq_d;
  logic                  done_q, done_d;
  logic                  ready_q, ready_d;
  logic [15:0]           act_q, act_d;
  logic                  seen_q, seen_d;
  logic                  wr_en, last;

  // Hold 0 is played as a single cycle.
  function automatic logic [HOLD_WIDTH-1:0] eff_hold(input logic [HOLD_WIDTH-1:0] h);
    return (h == '0) ? HOLD_WIDTH'(1) : h;
  endfunction

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    idx_d   = idx_q;
    hold_d  = hold_q;
    acked_d = acked_q;
    act_d   = act_q;
    seen_d  = seen_q;
    done_d  = 1'b0;
    wr_en   = 1'b0;
    nxt_idx = idx_q + IDX_W'(1);
    last    = ({1'b0, idx_q} + (IDX_W+1)'(1)) == count_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          act_d  = '0;
          seen_d = 1'b0;
          if (count_q == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = StPlay;
            idx_d   = '0;
            hold_d  = eff_hold(hold_mem[0]);
            acked_d = 1'b0;
          end
        end else if (clear) begin
          count_d = '0;
        end else if (load_valid && ready_q) begin
          wr_en   = 1'b1;
          count_d = count_q + (IDX_W+1)'(1);
        end
      end
      StPlay: begin
        if ((control_output_from_cpu != '0) && (act_q != 16'hFFFF)) begin
          act_d = act_q + 16'd1;
        end
        if (interrupt_grant_from_pc) begin
          seen_d  = 1'b1;
          acked_d = 1'b1;
        end
        if (abort) begin
          state_d = StIdle;
          idx_d   = '0;
        end else if (hold_q == HOLD_WIDTH'(1)) begin
          // Any entry change, including a loop wrap, re-arms the interrupt.
          acked_d = 1'b0;
          if (!last) begin
            idx_d  = nxt_idx;
            hold_d = eff_hold(hold_mem[nxt_idx]);
          end else if (loop_mode) begin
            idx_d  = '0;
            hold_d = eff_hold(hold_mem[0]);
          end else begin
            state_d = StIdle;
            idx_d   = '0;
            done_d  = 1'b1;
          end
        end else begin
          hold_d = hold_q - HOLD_WIDTH'(1);
        end
      end
      default: state_d = StIdle;
    endcase

    bus_d   = (state_d == StPlay) ? data_mem[idx_d] : '0;
    irq_d   = (state_d == StPlay) && irq_mem[idx_d] && !acked_d;
    ready_d = (state_d == StIdle) && (count_d != Full);
  end

  always_ff @(posedge clk_from_external or posedge reset_from_external) begin
    if (reset_from_external) begin
      state_q <= StIdle;
      count_q <= '0;
      idx_q   <= '0;
      hold_q  <= '0;
      acked_q <= 1'b0;
      bus_q   <= '0;
      irq_q   <= 1'b0;
      done_q  <= 1'b0;
      ready_q <= 1'b1;
      act_q   <= '0;
      seen_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      idx_q   <= idx_d;
      hold_q  <= hold_d;
      acked_q <= acked_d;
      bus_q   <= bus_d;
      irq_q   <= irq_d;
      done_q  <= done_d;
      ready_q <= ready_d;
      act_q   <= act_d;
      seen_q  <= seen_d;
    end
  end

  // Table storage is deliberately left out of reset.
  always_ff @(posedge clk_from_external) begin
    if (wr_en) begin
      data_mem[count_q[IDX_W-1:0]] <= load_data;
      hold_mem[count_q[IDX_W-1:0]] <= load_hold;
      irq_mem[count_q[IDX_W-1:0]]  <= load_irq;
    end
  end

  assign load_ready         = ready_q;
  assign inputdata_to_cpu   = bus_q;
  assign interrupt_to_cpu   = irq_q;
  assign busy               = (state_q == StPlay);
  assign done               = done_q;
  assign entry_count        = count_q;
  assign play_index         = idx_q;
  assign bus_activity_count = act_q;
  assign irq_grant_seen     = seen_q;

endmodule

// File: tb/tb_cpu_bus_sequencer.sv
// Bench for cpu_bus_sequencer: directed scenarios with literal expectations plus randomized
// traffic, all compared every cycle against a behavioural playback model.
module tb_cpu_bus_sequencer;
  localparam int DW = 32;
  localparam int DEPTH = 16;
  localparam int HW = 8;
  localparam int CW = 4;
  localparam int IW = 4;

  logic clk;
  logic rst;
  logic load_valid, load_irq, clear, start, loop_mode, abort, grant;
  logic [DW-1:0] load_data;
  logic [HW-1:0] load_hold;
  logic [CW-1:0] ctrl;
  logic load_ready, irq_out, busy, done, seen;
  logic [DW-1:0] bus;
  logic [IW:0] entry_count;
  logic [IW-1:0] play_index;
  logic [15:0] act;

  cpu_bus_sequencer #(
    .DATA_WIDTH(DW), .DEPTH(DEPTH), .HOLD_WIDTH(HW), .CTRL_WIDTH(CW)
  ) dut (
    .clk_from_external      (clk),
    .reset_from_external    (rst),
    .load_valid             (load_valid),
    .load_data              (load_data),
    .load_hold              (load_hold),
    .load_irq               (load_irq),
    .load_ready             (load_ready),
    .clear                  (clear),
    .start                  (start),
    .loop_mode              (loop_mode),
    .abort                  (abort),
    .interrupt_grant_from_pc(grant),
    .control_output_from_cpu(ctrl),
    .inputdata_to_cpu       (bus),
    .interrupt_to_cpu       (irq_out),
    .busy                   (busy),
    .done                   (done),
    .entry_count            (entry_count),
    .play_index             (play_index),
    .bus_activity_count     (act),
    .irq_grant_seen         (seen)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass = 0;
  bit cmp_en = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
  endtask

  // Behavioural model: table as arrays, playback tracked as elapsed cycles in current entry.
  logic [DW-1:0] m_data [DEPTH];
  int m_hold [DEPTH];
  bit m_irq [DEPTH];
  int m_count, m_idx, m_elapsed, m_act;
  bit m_play, m_acked, m_done, m_seen;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_count = 0; m_idx = 0; m_elapsed = 0; m_act = 0;
      m_play = 0; m_acked = 0; m_done = 0; m_seen = 0;
    end else begin
      m_done = 0;
      if (!m_play) begin
        if (start) begin
          m_act = 0;
          m_seen = 0;
          if (m_count == 0) m_done = 1;
          else begin
            m_play = 1; m_idx = 0; m_elapsed = 1; m_acked = 0;
          end
        end else if (clear) begin
          m_count = 0;
        end else if (load_valid && m_count < DEPTH) begin
          m_data[m_count] = load_data;
          m_hold[m_count] = int'(load_hold);
          m_irq[m_count] = load_irq;
          m_count++;
        end
      end else begin
        if (ctrl != 0 && m_act < 65535) m_act++;
        if (grant) begin
          m_seen = 1;
          m_acked = 1;
        end
        if (abort) m_play = 0;
        else if (m_elapsed >= ((m_hold[m_idx] == 0) ? 1 : m_hold[m_idx])) begin
          m_acked = 0;
          m_elapsed = 1;
          if (m_idx < m_count - 1) m_idx++;
          else if (loop_mode) m_idx = 0;
          else begin
            m_play = 0;
            m_done = 1;
          end
        end else m_elapsed++;
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check("busy", busy, m_play);
      check("done", done, m_done);
      check("bus", bus, m_play ? m_data[m_idx] : '0);
      check("irq", irq_out, m_play && m_irq[m_idx] && !m_acked);
      check("load_ready", load_ready, !m_play && m_count < DEPTH);
      check("entry_count", entry_count, m_count);
      check("activity", act, m_act);
      check("grant_seen", seen, m_seen);
      if (m_play) check("play_index", play_index, m_idx);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [DW-1:0] d, input int h, input bit q);
    load_valid = 1; load_data = d; load_hold = HW'(h); load_irq = q;
    tick();
    load_valid = 0;
  endtask

  task automatic do_clear();
    clear = 1;
    tick();
    clear = 0;
  endtask

  task automatic do_start();
    start = 1;
    tick();
    start = 0;
  endtask

  logic [DW-1:0] words [3];
  logic [11:0] mask;

  initial begin
    rst = 1;
    {load_valid, load_irq, clear, start, loop_mode, abort, grant} = '0;
    load_data = '0; load_hold = '0; ctrl = '0;
    words[0] = 32'h0020A0A3; words[1] = 32'h000010B7; words[2] = 32'h00108013;
    tick(); tick();
    check("rst_busy", busy, 0);
    check("rst_ready", load_ready, 1);
    check("rst_count", entry_count, 0);
    check("rst_bus", bus, 0);
    rst = 0;
    cmp_en = 1;
    tick();

    // Three words, hold 4 each.
    for (int i = 0; i < 3; i++) load(words[i], 4, 0);
    do_start();
    for (int k = 0; k < 12; k++) begin
      check("t1_bus", bus, words[k/4]);
      check("t1_busy", busy, 1);
      tick();
    end
    check("t1_done", done, 1);
    check("t1_busy_end", busy, 0);
    check("t1_bus_end", bus, 0);
    tick();
    check("t1_done_pulse", done, 0);

    // Interrupt acknowledge.
    do_clear();
    load(32'hCAFE0001, 8, 1);
    do_start();
    for (int k = 0; k < 8; k++) begin
      check("t2_irq", irq_out, k <= 3);
      grant = (k == 3);
      tick();
    end
    grant = 0;
    check("t2_done", done, 1);
    check("t2_seen", seen, 1);

    // Fill to capacity.
    do_clear();
    for (int i = 0; i < DEPTH; i++) begin
      check("t3_ready", load_ready, 1);
      load(DW'(i + 32'h100), 1, 0);
    end
    check("t3_full_ready", load_ready, 0);
    load(32'hDEADBEEF, 1, 0);
    check("t3_count", entry_count, DEPTH);
    do_clear();
    check("t3_clr_count", entry_count, 0);
    check("t3_clr_ready", load_ready, 1);

    // Loop and abort.
    load(32'hAAAA0000, 1, 0);
    load(32'hBBBB0000, 1, 0);
    loop_mode = 1;
    do_start();
    for (int k = 0; k < 5; k++) begin
      check("t4_bus", bus, (k % 2 == 0) ? 32'hAAAA0000 : 32'hBBBB0000);
      if (k == 4) abort = 1;
      tick();
    end
    abort = 0;
    loop_mode = 0;
    check("t4_busy", busy, 0);
    check("t4_done", done, 0);
    tick();
    check("t4_done_after", done, 0);

    // Empty start, then hold 0.
    do_clear();
    do_start();
    check("t5_done", done, 1);
    check("t5_busy", busy, 0);
    tick();
    check("t5_busy2", busy, 0);
    load(32'h0000C0C0, 0, 0);
    load(32'h0000D0D0, 2, 0);
    do_start();
    check("t5_h0", bus, 32'h0000C0C0);
    tick();
    check("t5_next", bus, 32'h0000D0D0);
    tick(); tick();
    check("t5_done2", done, 1);

    // Bus activity count: 7 of 12 cycles.
    do_clear();
    for (int i = 0; i < 3; i++) load(words[i], 4, 0);
    mask = 12'b101101011010;
    do_start();
    for (int k = 0; k < 12; k++) begin
      ctrl = mask[k] ? 4'h5 : 4'h0;
      tick();
    end
    ctrl = 0;
    check("t6_act", act, 7);

    // Asynchronous reset mid-play.
    do_clear();
    load(32'h12345678, 5, 1);
    load(32'h9ABCDEF0, 5, 0);
    ctrl = 4'h1;
    do_start();
    tick(); tick();
    check("t7_act_pre", act, 2);
    #2 rst = 1;
    #1;
    check("t7_busy", busy, 0);
    check("t7_bus", bus, 0);
    check("t7_irq", irq_out, 0);
    check("t7_count", entry_count, 0);
    check("t7_ready", load_ready, 1);
    check("t7_act", act, 0);
    rst = 0;
    ctrl = 0;
    tick();

    // Randomized traffic.
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 599) == 0) begin
        #1 rst = 1;
        #2 rst = 0;
      end
      load_valid = ($urandom_range(0, 9) < 4);
      load_data = $urandom;
      load_hold = HW'($urandom_range(0, 3));
      load_irq = ($urandom_range(0, 2) == 0);
      clear = ($urandom_range(0, 59) == 0);
      start = ($urandom_range(0, 14) == 0);
      abort = ($urandom_range(0, 49) == 0);
      grant = ($urandom_range(0, 7) == 0);
      ctrl = ($urandom_range(0, 1) == 0) ? '0 : CW'($urandom);
      if ($urandom_range(0, 19) == 0) loop_mode = ~loop_mode;
      tick();
    end
    {load_valid, clear, start, abort, grant, loop_mode} = '0;
    ctrl = '0;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/cpu_bus_sequencer.md
# cpu_bus_sequencer

Synthesizable, parametrised instruction-bus sequencer that replaces hand-timed stimulus for the `cpu` core. It holds a loadable table of bus words, each with a per-entry hold time and an interrupt flag. It drives the words onto the core's instruction/data input bus in order, raises the core's interrupt line on flagged entries, and counts bus activity returned by the core. It sits between the host/debug loader and the `cpu` external-bus ports, and is used on FPGA bring-up and in regression benches.

## Interface
- DATA_WIDTH, 32, width of bus word driven to the core
- DEPTH, 64, table entries (power of two, ≥2)
- HOLD_WIDTH, 8, width of per-entry hold count
- CTRL_WIDTH, 4, width of core control output
- IDX_W, $clog2(DEPTH), table index width (derived)

Ports:
- clk_from_external  in  1  system clock, rising edge
- reset_from_external  in  1  asynchronous, active-high reset
- load_valid  in  1  table write request
- load_data  in  DATA_WIDTH  bus word to append
- load_hold  in  HOLD_WIDTH  cycles to hold this word (0 treated as 1)
- load_irq  in  1  assert interrupt while this entry plays
- load_ready  out  1  high when IDLE and table not full
- clear  in  1  empty the table (IDLE only)
- start  in  1  begin playback (IDLE only)
- loop_mode  in  1  restart at entry 0 after last entry
- abort  in  1  stop playback
- interrupt_grant_from_pc  in  1  core interrupt acknowledge
- control_output_from_cpu  in  CTRL_WIDTH  core bus control
- inputdata_to_cpu  out  DATA_WIDTH  drives core inputdata_from_external_bus
- interrupt_to_cpu  out  1  drives core interrupt_from_external
- busy  out  1  high in PLAY
- done  out  1  one-cycle pulse on normal completion
- entry_count  out  IDX_W+1  entries loaded
- play_index  out  IDX_W  entry currently driven
- bus_activity_count  out  16  PLAY cycles with control_output_from_cpu ≠ 0; saturates at 0xFFFF
- irq_grant_seen  out  1  sticky: grant observed during PLAY

## Operation
- States: IDLE, PLAY. Reset value of every output is 0, except load_ready=1. Table contents are not reset.
- IDLE: `load_valid && load_ready` writes {data, hold, irq} at entry_count, then entry_count++. When entry_count==DEPTH, load_ready=0 and writes are ignored. `clear` sets entry_count=0 and has priority over `load_valid` in the same cycle.
- `start` in IDLE clears bus_activity_count and irq_grant_seen.
  - If entry_count==0: emit done next cycle and stay in IDLE.
  - Otherwise go to PLAY with play_index=0 and hold counter = max(hold[0],1).
- PLAY:
  - inputdata_to_cpu = data[play_index].
  - interrupt_to_cpu = irq[play_index] && !acked. `acked` sets on the cycle after interrupt_grant_from_pc is high and clears on each entry change.
  - The hold counter decrements each cycle. At 1 the sequencer advances:
    - to the next entry, or
    - if last entry and loop_mode=1 (sampled at that cycle): to entry 0, or
    - if last entry and loop_mode=0: to IDLE and pulse done.
- `abort` in PLAY: go to IDLE next edge, no done pulse, table and counters retained. Abort has priority over advance.
- `start`, `clear` and `load_valid` are ignored in PLAY.
- In IDLE, inputdata_to_cpu=0 and interrupt_to_cpu=0.
- bus_activity_count and irq_grant_seen update only in PLAY.
- Asynchronous reset mid-PLAY: immediate IDLE, all outputs reset, entry_count=0.

## Timing
- All outputs are registered.
- `start` sampled at edge T: from T, busy=1 and inputdata_to_cpu=data[0].
- An entry with hold H occupies exactly H cycles; hold 0 occupies 1 cycle.
- A non-looping run of N entries lasts Σmax(hold_i,1) cycles. done=1 for the single cycle immediately following, coincident with busy=0.
- Entry transitions have no gap cycle. A loop wrap is also gapless.
- Grant high at edge G: interrupt_to_cpu=0 from G+1 until the entry changes.
- Load throughput: 1 entry per cycle.

## Test plan
- Load 3 entries (SW 0x0020A0A3, LUI 0x000010B7 encoding, ADDI 0x00108013), each hold=4, then start → each word on the bus for exactly 4 cycles. done pulses at cycle 12 after start, busy=0, bus returns to 0.
- Entry 0: hold=8, irq=1. Grant at cycle 3 → interrupt_to_cpu high for cycles 0–3, low from cycle 4. irq_grant_seen=1 at the end.
- Load DEPTH entries → load_ready drops after the DEPTH-th write. An extra write is ignored and entry_count=DEPTH. Then clear → entry_count=0 and load_ready=1.
- loop_mode=1 with 2 entries of hold 1 → bus alternates A, B, A, B with no gap. abort after 5 cycles → IDLE next cycle, no done pulse.
- Start with an empty table → done one cycle later, busy never high. An entry with hold=0 plays for 1 cycle.
- control_output_from_cpu nonzero for 7 of 12 play cycles → bus_activity_count=7. Reset asserted mid-PLAY → all outputs 0 at once and entry_count=0.
